// File: rtl/tmds_decoder.sv
// TMDS receive decoder for one DVI channel: finds the symbol boundary from
// control tokens in the deserialized stream, then decodes video data and control codes.
module tmds_decoder #(
   parameter int LOCK_TOKENS    = 8,
   parameter int SEARCH_TIMEOUT = 2048,
   parameter int LOSS_TIMEOUT   = 1048576
) (
   input  logic       pixclk,
   input  logic       reset,
   input  logic [9:0] raw_in,
   output logic [7:0] data,
   output logic [1:0] ctrl,
   output logic       vde,
   output logic       locked,
   output logic [3:0] offset
);

   localparam int TOK_W   = (LOCK_TOKENS > 1) ? $clog2(LOCK_TOKENS) : 1;
   localparam int TMO_MAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
   localparam int TMO_W   = (TMO_MAX > 1) ? $clog2(TMO_MAX) : 1;

   localparam logic [TOK_W-1:0] TOK_LAST    = TOK_W'(LOCK_TOKENS - 1);
   localparam logic [TMO_W-1:0] SEARCH_LAST = TMO_W'(SEARCH_TIMEOUT - 1);
   localparam logic [TMO_W-1:0] LOSS_LAST   = TMO_W'(LOSS_TIMEOUT - 1);

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t           state;
   logic [9:0]       raw_q;
   logic [9:0]       raw_qq;
   logic [19:0]      window;
   logic [9:0]       sym;
   logic             is_tok;
   logic [1:0]       tok_code;
   logic [7:0]       q;
   logic [7:0]       d;
   logic [TOK_W-1:0] tok_cnt;
   logic [TMO_W-1:0] tmo_cnt;

   always_ff @(posedge pixclk) begin
      if (reset) begin
         raw_q  <= 10'h000;
         raw_qq <= 10'h000;
      end else begin
         raw_q  <= raw_in;
         raw_qq <= raw_q;
      end
   end

   // Older word sits in the low half, so bit 0 of the window is the earliest bit.
   assign window = {raw_q, raw_qq};

   always_comb begin
      sym = window[9:0];
      case (offset)
         4'd1:    sym = window[10:1];
         4'd2:    sym = window[11:2];
         4'd3:    sym = window[12:3];
         4'd4:    sym = window[13:4];
         4'd5:    sym = window[14:5];
         4'd6:    sym = window[15:6];
         4'd7:    sym = window[16:7];
         4'd8:    sym = window[17:8];
         4'd9:    sym = window[18:9];
         default: sym = window[9:0];
      endcase
   end

   always_comb begin
      is_tok   = 1'b1;
      tok_code = 2'b00;
      case (sym)
         10'h354: tok_code = 2'b00;
         10'h0AB: tok_code = 2'b01;
         10'h154: tok_code = 2'b10;
         10'h2AB: tok_code = 2'b11;
         default: is_tok   = 1'b0;
      endcase
   end

   // Undo the optional inversion (bit 9), then the XOR/XNOR chain selected by bit 8.
   always_comb begin
      q    = sym[9] ? ~sym[7:0] : sym[7:0];
      d    = 8'h00;
      d[0] = q[0];
      for (int i = 1; i < 8; i++) begin
         d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      end
   end

   always_ff @(posedge pixclk) begin
      if (reset) begin
         data <= 8'h00;
         ctrl <= 2'b00;
         vde  <= 1'b0;
      end else if (is_tok) begin
         ctrl <= tok_code;
         vde  <= 1'b0;
         data <= 8'h00;
      end else begin
         vde  <= (state == LOCKED);
         data <= (state == LOCKED) ? d : 8'h00;
      end
   end

   always_ff @(posedge pixclk) begin
      if (reset) begin
         state   <= SEARCH;
         locked  <= 1'b0;
         offset  <= 4'd0;
         tok_cnt <= '0;
         tmo_cnt <= '0;
      end else begin
         case (state)
            SEARCH: begin
               if (is_tok && (tok_cnt == TOK_LAST)) begin
                  state   <= LOCKED;
                  locked  <= 1'b1;
                  tok_cnt <= '0;
                  tmo_cnt <= '0;
               end else if (tmo_cnt == SEARCH_LAST) begin
                  offset  <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                  tok_cnt <= '0;
                  tmo_cnt <= '0;
               end else begin
                  tok_cnt <= is_tok ? tok_cnt + TOK_W'(1) : '0;
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            LOCKED: begin
               // tmo_cnt doubles as the loss timer; any token restarts it.
               if (is_tok) begin
                  tmo_cnt <= '0;
               end else if (tmo_cnt == LOSS_LAST) begin
                  state   <= SEARCH;
                  locked  <= 1'b0;
                  tok_cnt <= '0;
                  tmo_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            default: begin
               state  <= SEARCH;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: symbol-stream stimulus at a chosen bit shift, a
// stream-level reference model compared every cycle, plus directed literal checks.
module tb_tmds_decoder;

   localparam int LOCK_TOKENS    = 8;
   localparam int SEARCH_TIMEOUT = 16;
   localparam int LOSS_TIMEOUT   = 16;

   localparam logic [9:0] TOK00 = 10'h354;
   localparam logic [9:0] TOK01 = 10'h0AB;
   localparam logic [9:0] TOK10 = 10'h154;
   localparam logic [9:0] TOK11 = 10'h2AB;
   localparam logic [9:0] D_00  = 10'h100;
   localparam logic [9:0] D_FF  = 10'h200;

   logic       pixclk = 1'b0;
   logic       reset  = 1'b1;
   logic [9:0] raw_in = 10'h000;
   logic [7:0] data;
   logic [1:0] ctrl;
   logic       vde;
   logic       locked;
   logic [3:0] offset;

   int         n_checks = 0;
   int         n_fail   = 0;
   bit         chk_en   = 1'b0;
   int         shift    = 0;
   logic [9:0] prev_sym = 10'h000;
   logic [10:0] exp_q[$];

   tmds_decoder #(
      .LOCK_TOKENS   (LOCK_TOKENS),
      .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
      .LOSS_TIMEOUT  (LOSS_TIMEOUT)
   ) dut (
      .pixclk(pixclk),
      .reset (reset),
      .raw_in(raw_in),
      .data  (data),
      .ctrl  (ctrl),
      .vde   (vde),
      .locked(locked),
      .offset(offset)
   );

   // ---------------- clock ----------------
   always #5 pixclk = ~pixclk;

   // ---------------- reference model ----------------
   function automatic logic [9:0] stream_sym(input logic [9:0] newer, input logic [9:0] older,
                                             input int off);
      logic [9:0] s;
      s = 10'h000;
      for (int j = 0; j < 10; j++) begin
         if (off + j < 10) s[j] = older[off + j];
         else              s[j] = newer[off + j - 10];
      end
      return s;
   endfunction

   function automatic logic [2:0] tok_lookup(input logic [9:0] s);
      case (s)
         TOK00:   return 3'b100;
         TOK01:   return 3'b101;
         TOK10:   return 3'b110;
         TOK11:   return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [7:0] tmds_decode(input logic [9:0] s);
      logic [7:0] qv;
      logic [7:0] dv;
      qv = s[9] ? ~s[7:0] : s[7:0];
      dv = 8'h00;
      dv[0] = qv[0];
      for (int i = 1; i < 8; i++) dv[i] = s[8] ? (qv[i] ^ qv[i-1]) : ~(qv[i] ^ qv[i-1]);
      return dv;
   endfunction

   logic [9:0] m_w1, m_w0;
   logic [7:0] m_data;
   logic [1:0] m_ctrl;
   logic       m_vde;
   logic       m_locked;
   int         m_off, m_run, m_dwell, m_quiet;
   logic [9:0] m_sym;
   logic [2:0] m_tk;

   assign m_sym = stream_sym(m_w1, m_w0, m_off);
   assign m_tk  = tok_lookup(m_sym);

   always @(posedge pixclk) begin
      if (reset) begin
         m_w1 <= 10'h000; m_w0 <= 10'h000;
         m_data <= 8'h00; m_ctrl <= 2'b00; m_vde <= 1'b0; m_locked <= 1'b0;
         m_off <= 0; m_run <= 0; m_dwell <= 0; m_quiet <= 0;
      end else begin
         m_w1 <= raw_in;
         m_w0 <= m_w1;
         if (m_tk[2]) begin
            m_ctrl <= m_tk[1:0]; m_vde <= 1'b0; m_data <= 8'h00;
         end else begin
            m_vde  <= m_locked;
            m_data <= m_locked ? tmds_decode(m_sym) : 8'h00;
         end
         if (!m_locked) begin
            if (m_tk[2] && (m_run + 1 == LOCK_TOKENS)) begin
               m_locked <= 1'b1; m_run <= 0; m_dwell <= 0; m_quiet <= 0;
            end else if (m_dwell + 1 == SEARCH_TIMEOUT) begin
               m_off <= (m_off + 1) % 10; m_run <= 0; m_dwell <= 0;
            end else begin
               m_run   <= m_tk[2] ? m_run + 1 : 0;
               m_dwell <= m_dwell + 1;
            end
         end else begin
            if (m_tk[2]) m_quiet <= 0;
            else if (m_quiet + 1 == LOSS_TIMEOUT) begin
               m_locked <= 1'b0; m_quiet <= 0; m_run <= 0; m_dwell <= 0;
            end else m_quiet <= m_quiet + 1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge pixclk) begin
      if (chk_en) begin
         check("model_data",   data,   m_data);
         check("model_ctrl",   ctrl,   m_ctrl);
         check("model_vde",    vde,    m_vde);
         check("model_locked", locked, m_locked);
         check("model_offset", offset, m_off);
      end
   end

   // ---------------- drivers ----------------
   task automatic drive(input logic [9:0] w);
      raw_in = w;
      @(posedge pixclk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset  = 1'b1;
      raw_in = 10'h000;
      repeat (n) @(posedge pixclk);
      #1;
      reset  = 1'b0;
   endtask

   // Symbols start at bit 'shift' of each word; the rest spills into the next word.
   task automatic send_sym(input logic [9:0] s);
      logic [19:0] pair;
      pair     = {s, prev_sym};
      pair     = pair >> (10 - shift);
      prev_sym = s;
      drive(pair[9:0]);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_data"},   data,   8'h00);
      check({tag, "_ctrl"},   ctrl,   2'b00);
      check({tag, "_vde"},    vde,    1'b0);
      check({tag, "_locked"}, locked, 1'b0);
      check({tag, "_offset"}, offset, 4'd0);
   endtask

   function automatic logic [9:0] rand_tok();
      case ($urandom_range(0, 3))
         0:       return TOK00;
         1:       return TOK01;
         2:       return TOK10;
         default: return TOK11;
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [9:0]  dec_w[7];
      logic [10:0] dec_e[7];
      logic [10:0] e;
      int          burst;

      dec_w = '{D_00, D_FF, TOK01, TOK11, TOK10, D_00, D_00};
      dec_e = '{{1'b1, 2'b00, 8'h00}, {1'b1, 2'b00, 8'hFF}, {1'b0, 2'b01, 8'h00},
                {1'b0, 2'b11, 8'h00}, {1'b0, 2'b10, 8'h00}, {1'b1, 2'b10, 8'h00},
                {1'b1, 2'b10, 8'h00}};

      do_reset(2);
      chk_en = 1'b1;
      check_zero("reset");

      // aligned lock: 8th token window closes after the 9th word
      shift = 0; prev_sym = TOK00;
      repeat (9) send_sym(TOK00);
      check("aligned_not_yet", locked, 1'b0);
      send_sym(TOK00);
      check("aligned_locked", locked, 1'b1);
      check("aligned_offset", offset, 4'd0);
      check("aligned_ctrl",   ctrl,   2'b00);
      check("aligned_vde",    vde,    1'b0);

      // decode: outputs appear two drives after the symbol's word
      for (int i = 0; i < 9; i++) begin
         send_sym((i < 7) ? dec_w[i] : D_00);
         if (i < 7) exp_q.push_back(dec_e[i]);
         if (i >= 2) begin
            e = exp_q.pop_front();
            check("decode_out", {vde, ctrl, data}, e);
         end
      end
      check("prereset_locked", locked, 1'b1);

      do_reset(1);
      check_zero("midlock_reset");

      // misaligned: token begins at bit 3 of each word
      shift = 3; prev_sym = TOK00;
      repeat (47) send_sym(TOK00);
      check("mis_offset2", offset, 4'd2);
      send_sym(TOK00);
      check("mis_offset3", offset, 4'd3);
      repeat (7) send_sym(TOK00);
      check("mis_not_yet", locked, 1'b0);
      send_sym(TOK00);
      check("mis_locked", locked, 1'b1);
      check("mis_lock_offset", offset, 4'd3);

      // loss of lock at offset 3
      repeat (15) send_sym(D_00);
      send_sym(TOK00);
      repeat (17) send_sym(D_00);
      check("loss_still_locked", locked, 1'b1);
      send_sym(D_00);
      check("loss_dropped", locked, 1'b0);
      check("loss_offset_kept", offset, 4'd3);
      send_sym(D_00);
      check("loss_vde_low", vde, 1'b0);

      // offset wrap with no tokens present
      do_reset(1);
      shift = 0; prev_sym = D_00;
      repeat (144) send_sym(D_00);
      check("wrap_offset9", offset, 4'd9);
      repeat (15) send_sym(D_00);
      check("wrap_offset9_end", offset, 4'd9);
      send_sym(D_00);
      check("wrap_offset0", offset, 4'd0);
      check("wrap_unlocked", locked, 1'b0);

      // randomized symbol streams at random bit shifts
      for (int seg = 0; seg < 10; seg++) begin
         if ($urandom_range(0, 2) == 0) do_reset(1);
         shift = $urandom_range(0, 9);
         burst = 0;
         for (int n = 0; n < 400; n++) begin
            if (burst == 0 && $urandom_range(0, 99) < 15) burst = $urandom_range(1, 12);
            if (burst > 0) begin
               send_sym(rand_tok());
               burst--;
            end else begin
               send_sym(10'($urandom_range(0, 1023)));
            end
         end
      end

      repeat (3) drive(10'h000);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
